// File: rtl/overlay_scheduler_if.sv
// rtl/overlay_scheduler_if.sv - request/enable bundle between game FSM, VGA timing and overlay scheduler
//
// Purpose: groups the overlay request levels, the pixel counters and the
// registered overlay enables into one bundle.
// Signals:
//   req      [5:0]  level requests [0]Q1 [1]Q2 [2]Q3 [3]G1 [4]G2 [5]G3
//   hCount   [9:0]  current horizontal pixel count
//   vCount   [9:0]  current vertical line count
//   en       [5:0]  one-hot overlay enable (all-zero = no overlay)
//   quiz_en         any quiz overlay (Q1..Q3) enabled
//   game_en         any game overlay (G1..G3) enabled
//   busy            scheduler is arming or showing
// Modports: master = request/timing source, slave = scheduler.

interface overlay_scheduler_if;
    logic [5:0] req;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic [5:0] en;
    logic       quiz_en;
    logic       game_en;
    logic       busy;

    modport master (
        output req, hCount, vCount,
        input  en, quiz_en, game_en, busy
    );

    modport slave (
        input  req, hCount, vCount,
        output en, quiz_en, game_en, busy
    );
endinterface

// File: rtl/overlay_scheduler.sv
// rtl/overlay_scheduler.sv - frame-synchronous arbiter for the six prompt overlays
//
// Purpose: picks the lowest-numbered eligible overlay request, changes the
// enables only on the end-of-frame tick and keeps a granted overlay up for at
// least MIN_FRAMES frames.
// Optional feature macro: OVL_TIMEOUT_EN (auto-dismiss after MAX_FRAMES frames,
// masking that request until it is released).
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   ovl   overlay_scheduler_if.slave (req/hCount/vCount in, en/quiz_en/game_en/busy out)
// Parameters: H_LAST, V_LAST (last pixel/line of a frame), MIN_FRAMES (>=1),
//   MAX_FRAMES (> MIN_FRAMES, only used with OVL_TIMEOUT_EN).

module overlay_scheduler #(
    parameter int H_LAST     = 799,
    parameter int V_LAST     = 524,
    parameter int MIN_FRAMES = 30,
    parameter int MAX_FRAMES = 600
) (
    input  logic          clk,
    input  logic          rst,
    overlay_scheduler_if.slave ovl
);

    localparam int HOLD_W = $clog2(MIN_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [5:0]          en_q, en_d;
    logic                quiz_en_q, quiz_en_d;
    logic                game_en_q, game_en_d;
    logic                busy_q, busy_d;
    logic                fc_q;

    logic                fc;
    logic                tick;
    logic [5:0]          mask_q;
    logic [5:0]          mask_set;
    logic [5:0]          elig;
    logic [5:0]          winner;
    logic                hold_done;
    logic                load;

    // The pixel counts sit at end-of-frame for several clocks; only the
    // first of those clocks counts as the frame tick.
    assign fc   = (ovl.hCount == 10'(H_LAST)) && (ovl.vCount == 10'(V_LAST));
    assign tick = fc & ~fc_q;

`ifdef OVL_TIMEOUT_EN
    logic [9:0] show_cnt_q, show_cnt_d;
    logic [5:0] mask_d;
    logic       timeout;

    // Timeout fires on the tick that would make the show count reach MAX_FRAMES.
    assign timeout  = (state_q == S_SHOW) && tick && ((show_cnt_q + 10'd1) == 10'(MAX_FRAMES));
    assign mask_set = timeout ? en_q : 6'd0;
    // A masked request is re-armed as soon as it is released for one cycle.
    assign mask_d   = (mask_q | mask_set) & ovl.req;

    always_comb begin
        show_cnt_d = show_cnt_q;
        if (load) begin
            show_cnt_d = 10'd0;
        end else if ((state_q == S_SHOW) && tick && (show_cnt_q != 10'(MAX_FRAMES))) begin
            show_cnt_d = show_cnt_q + 10'd1;
        end
    end
`else
    logic unused_cfg;

    assign mask_q     = 6'd0;
    assign mask_set   = 6'd0;
    assign unused_cfg = (MAX_FRAMES > MIN_FRAMES);
`endif

    // A just-timed-out overlay is already excluded from the decision on its own tick.
    assign elig   = ovl.req & ~(mask_q | mask_set);
    assign winner = elig & (~elig + 6'd1);

    // hold_cnt_q counts completed frames since the grant; the tick that
    // brings it to MIN_FRAMES is the first one allowed to change en.
    assign hold_done = (hold_cnt_q >= HOLD_W'(MIN_FRAMES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            en_q       <= 6'd0;
            quiz_en_q  <= 1'b0;
            game_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            fc_q       <= 1'b0;
`ifdef OVL_TIMEOUT_EN
            show_cnt_q <= 10'd0;
            mask_q     <= 6'd0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            en_q       <= en_d;
            quiz_en_q  <= quiz_en_d;
            game_en_q  <= game_en_d;
            busy_q     <= busy_d;
            fc_q       <= fc;
`ifdef OVL_TIMEOUT_EN
            show_cnt_q <= show_cnt_d;
            mask_q     <= mask_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (|elig) state_d = S_ARM;
            S_ARM:  if (tick) state_d = (|elig) ? S_SHOW : S_IDLE;
            S_SHOW: if (tick && hold_done && !(|elig)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic (values registered by the state register)
    always_comb begin
        en_d       = en_q;
        hold_cnt_d = hold_cnt_q;
        load       = 1'b0;
        case (state_q)
            S_ARM: begin
                if (tick && (|elig)) begin
                    en_d       = winner;
                    hold_cnt_d = '0;
                    load       = 1'b1;
                end
            end
            S_SHOW: begin
                if (tick) begin
                    if (hold_cnt_q != HOLD_W'(MIN_FRAMES)) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                    if (hold_done) begin
                        if (!(|elig)) begin
                            en_d = 6'd0;
                        end else if (winner != en_q) begin
                            // Direct hand-over: no blank frame between overlays.
                            en_d       = winner;
                            hold_cnt_d = '0;
                            load       = 1'b1;
                        end
                    end
                end
            end
            default: en_d = 6'd0;
        endcase
        quiz_en_d = |en_d[2:0];
        game_en_d = |en_d[5:3];
        busy_d    = (state_d != S_IDLE);
    end

    assign ovl.en      = en_q;
    assign ovl.quiz_en = quiz_en_q;
    assign ovl.game_en = game_en_q;
    assign ovl.busy    = busy_q;

endmodule
